// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// state encoding, opcode/funct constants and datapath mux/ALU encodings.
package mc_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_IEXEC   = 4'd10,
      S_IWB     = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes, shared with the ALU
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BRIMM = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Final step of a completed instruction; these always return to FETCH
   function automatic logic retires(input state_t s);
      logic r;
      case (s)
         S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_IWB, S_JUMP: r = 1'b1;
         default:                                            r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: selects ALUControl and immediate extension from the current
// control step, opcode and funct, and flags unsupported R-type funct codes.
module mc_control_fsm_alu_decoder
   import mc_control_fsm_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       extop,
   output logic       funct_illegal
);

   // ALU operation per step; address/PC arithmetic steps all use add
   always_comb begin
      alucontrol    = ALU_ADD;
      extop         = 1'b0;
      funct_illegal = 1'b0;
      case (state)
         S_BRANCH: alucontrol = ALU_SUB;
         S_EXECUTE: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         S_IEXEC: begin
            case (opcode)
               OP_ANDI: begin
                  alucontrol = ALU_AND;
                  extop      = 1'b1;
               end
               OP_ORI: begin
                  alucontrol = ALU_OR;
                  extop      = 1'b1;
               end
               OP_SLTI: alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle Moore control FSM for the MIPS-subset datapath; drives all
// datapath enables/muxes and counts retired instructions.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             Zero,
   output logic             PCEn,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             ExtOp,
   output logic [2:0]       ALUControl,
   output logic [1:0]       PCSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state
);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] retired_r;
   logic             pcwrite_s;
   logic             branch_s;
   logic             funct_illegal_s;
   logic [2:0]       aluctl_s;
   logic             extop_s;

   mc_control_fsm_alu_decoder u_alu_decoder (
      .state         (state_r),
      .opcode        (opcode),
      .funct         (funct),
      .alucontrol    (aluctl_s),
      .extop         (extop_s),
      .funct_illegal (funct_illegal_s)
   );

   // State register and retired-instruction counter (reset abandons the instruction)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         retired_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (retires(state_r)) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Next-state selection and Moore datapath controls
   always_comb begin
      state_nxt_s = S_FETCH;
      pcwrite_s   = 1'b0;
      branch_s    = 1'b0;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      PCSrc       = PCSRC_ALU;
      illegal     = 1'b0;
      case (state_r)
         S_IDLE: state_nxt_s = S_FETCH;
         S_FETCH: begin
            IRWrite     = 1'b1;
            ALUSrcB     = SRCB_FOUR;
            pcwrite_s   = 1'b1;
            state_nxt_s = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_BRIMM;
            case (opcode)
               OP_LW, OP_SW:                      state_nxt_s = S_MEMADR;
               OP_RTYPE:                          state_nxt_s = S_EXECUTE;
               OP_BEQ:                            state_nxt_s = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt_s = S_IEXEC;
               OP_J:                              state_nxt_s = S_JUMP;
               default: begin
                  state_nxt_s = S_FETCH;
                  illegal     = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            if (opcode == OP_LW) begin
               state_nxt_s = S_MEMRD;
            end else begin
               state_nxt_s = S_MEMWR;
            end
         end
         S_MEMRD: begin
            IorD        = 1'b1;
            state_nxt_s = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            if (funct_illegal_s) begin
               illegal     = 1'b1;
               state_nxt_s = S_FETCH;
            end else begin
               state_nxt_s = S_ALUWB;
            end
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            PCSrc    = PCSRC_ALUOUT;
            branch_s = 1'b1;
         end
         S_IEXEC: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_IMM;
            state_nxt_s = S_IWB;
         end
         S_IWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc     = PCSRC_JUMP;
            pcwrite_s = 1'b1;
         end
         default: state_nxt_s = S_FETCH;
      endcase
   end

   assign PCEn       = pcwrite_s | (branch_s & Zero);
   assign ALUControl = aluctl_s;
   assign ExtOp      = extop_s;
   assign retired    = retired_r;
   assign state      = state_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected outputs come from an
// instruction-level model and are checked by an independent monitor.
module tb_mc_control_fsm;

   localparam int CW = 4;

   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                  ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXECUTE = 7,
                  ST_ALUWB = 8, ST_BRANCH = 9, ST_IEXEC = 10, ST_IWB = 11,
                  ST_JUMP = 12;

   typedef struct packed {
      logic [3:0]    st;
      logic          pcen;
      logic          iord;
      logic          memwrite;
      logic          irwrite;
      logic          regdst;
      logic          memtoreg;
      logic          regwrite;
      logic          alusrca;
      logic [1:0]    alusrcb;
      logic          extop;
      logic [2:0]    aluc;
      logic [1:0]    pcsrc;
      logic          illegal;
      logic [CW-1:0] ret;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic          Zero;
   logic          PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0]    ALUSrcB;
   logic          ExtOp;
   logic [2:0]    ALUControl;
   logic [1:0]    PCSrc;
   logic          illegal;
   logic [CW-1:0] retired;
   logic [3:0]    state;

   always #5 clk = ~clk;

   mc_control_fsm #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
      .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUControl(ALUControl), .PCSrc(PCSrc),
      .illegal(illegal), .retired(retired), .state(state)
   );

   obs_t act;
   assign act = {state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ExtOp, ALUControl, PCSrc, illegal, retired};

   obs_t expq[$];
   int   path_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   ret_model = 0;

   // R-type funct -> ALU code, -1 when unsupported
   function automatic int r_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 0;
         6'b100010: return 1;
         6'b100100: return 2;
         6'b100101: return 3;
         6'b101010: return 5;
         default:   return -1;
      endcase
   endfunction

   function automatic bit is_iop(input logic [5:0] op);
      return (op == 6'b001000) || (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001010);
   endfunction

   function automatic bit known_op(input logic [5:0] op);
      return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
             (op == 6'b000100) || (op == 6'b000010) || is_iop(op);
   endfunction

   // Sequence of control steps an instruction walks through
   function automatic void build_path(input logic [5:0] op, input logic [5:0] fn);
      path_q = {};
      path_q.push_back(ST_FETCH);
      path_q.push_back(ST_DECODE);
      if (op == 6'b100011) begin
         path_q.push_back(ST_MEMADR); path_q.push_back(ST_MEMRD); path_q.push_back(ST_MEMWB);
      end else if (op == 6'b101011) begin
         path_q.push_back(ST_MEMADR); path_q.push_back(ST_MEMWR);
      end else if (op == 6'b000000) begin
         path_q.push_back(ST_EXECUTE);
         if (r_alu(fn) >= 0) path_q.push_back(ST_ALUWB);
      end else if (op == 6'b000100) begin
         path_q.push_back(ST_BRANCH);
      end else if (is_iop(op)) begin
         path_q.push_back(ST_IEXEC); path_q.push_back(ST_IWB);
      end else if (op == 6'b000010) begin
         path_q.push_back(ST_JUMP);
      end
   endfunction

   function automatic obs_t expect_out(input int st, input logic [5:0] op,
                                       input logic [5:0] fn, input logic z, input int ret);
      obs_t e;
      int   code;
      e     = '0;
      e.st  = 4'(st);
      e.ret = CW'(ret);
      case (st)
         ST_FETCH:  begin e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1; end
         ST_DECODE: begin e.alusrcb = 2'b11; e.illegal = !known_op(op); end
         ST_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         ST_MEMRD:  e.iord = 1'b1;
         ST_MEMWB:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
         ST_MEMWR:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
         ST_EXECUTE: begin
            e.alusrca = 1'b1;
            code = r_alu(fn);
            if (code < 0) e.illegal = 1'b1;
            else          e.aluc = 3'(code);
         end
         ST_ALUWB:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
         ST_BRANCH: begin e.alusrca = 1'b1; e.aluc = 3'd1; e.pcsrc = 2'b01; e.pcen = z; end
         ST_IEXEC: begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            if (op == 6'b001100)      begin e.aluc = 3'd2; e.extop = 1'b1; end
            else if (op == 6'b001101) begin e.aluc = 3'd3; e.extop = 1'b1; end
            else if (op == 6'b001010) e.aluc = 3'd5;
            else                      e.aluc = 3'd0;
         end
         ST_IWB:  e.regwrite = 1'b1;
         ST_JUMP: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
         default: e.st = 4'(st);
      endcase
      return e;
   endfunction

   // Monitor: every cycle with a queued expectation is compared
   always @(negedge clk) begin
      obs_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         n_checks++;
         if (act === e) n_pass++;
         else $display("FAIL outputs(state %0d) got %h required %h", e.st, act, e);
      end
   end

   // Entered just after the edge into FETCH; returns just after the next one
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int abort_at);
      bit retire;
      build_path(op, fn);
      for (int i = 0; i < path_q.size(); i++) begin
         if (i == 0) begin
            opcode = op; funct = fn; Zero = z;
         end else begin
            @(posedge clk); #1;
         end
         expq.push_back(expect_out(path_q[i], op, fn, z, ret_model));
         if (i == abort_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            ret_model = 0;
            expq.push_back(expect_out(ST_IDLE, op, fn, z, ret_model));
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
         end
      end
      retire = (path_q[path_q.size()-1] != ST_DECODE) && (path_q[path_q.size()-1] != ST_EXECUTE);
      @(posedge clk); #1;
      if (retire) ret_model = (ret_model + 1) % (1 << CW);
   endtask

   logic [5:0] d_op[13] = '{6'b100011, 6'b100011, 6'b000000, 6'b000000, 6'b000100, 6'b000100,
                            6'b001101, 6'b001010, 6'b101011, 6'b000010, 6'b001000, 6'b001100, 6'b111111};
   logic [5:0] d_fn[13] = '{6'd0, 6'd0, 6'b101010, 6'b000111, 6'd0, 6'd0,
                            6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
   logic       d_z[13]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   int         d_ab[13] = '{3, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};

   initial begin
      logic [5:0] op;
      logic [5:0] fn;
      int         r;
      rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; Zero = 1'b0;
      @(posedge clk); #1;
      expq.push_back(expect_out(ST_IDLE, opcode, funct, Zero, 0));
      @(posedge clk); #1;
      expq.push_back(expect_out(ST_IDLE, opcode, funct, Zero, 0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 13; k++) run_instr(d_op[k], d_fn[k], d_z[k], d_ab[k]);

      for (int k = 0; k < 80; k++) begin
         r  = int'($urandom_range(0, 9));
         fn = 6'($urandom_range(0, 63));
         case (r)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: begin
               op = 6'b000000;
               if ($urandom_range(0, 5) != 0) begin
                  case ($urandom_range(0, 4))
                     0: fn = 6'b100000;
                     1: fn = 6'b100010;
                     2: fn = 6'b100100;
                     3: fn = 6'b100101;
                     default: fn = 6'b101010;
                  endcase
               end
            end
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b001100;
            6: op = 6'b001101;
            7: op = 6'b001010;
            8: op = 6'b000010;
            default: op = 6'($urandom_range(0, 63));
         endcase
         run_instr(op, fn, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
      end

      @(negedge clk); #1;
      n_checks++;
      if (expq.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending required 0", expq.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
